// File: rtl/length_load_counter.sv
// length_load_counter: programmable-length terminal-count detector plus loadable address counter
module length_load_counter #(
    parameter int LENGTH_WIDTH  = 32,
    parameter int ADDRESS_WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [LENGTH_WIDTH-1:0]  end_val,
    input  logic                     length_load,
    output logic                     count_event,
    input  logic [ADDRESS_WIDTH-1:0] start_val,
    input  logic                     address_load,
    output logic [ADDRESS_WIDTH-1:0] count_val
);
    logic [LENGTH_WIDTH-1:0]  count_q;
    logic [LENGTH_WIDTH-1:0]  end_q;
    logic [LENGTH_WIDTH-1:0]  end_eff;
    logic [ADDRESS_WIDTH-1:0] addr_q;

    // Length section: end register captures on load, counter free-runs while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            end_q   <= '0;
        end else begin
            if (length_load) end_q <= end_val;
            if (enable) count_q <= count_q + 1'b1;
        end
    end

    // Address section: a load wins over an increment on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else if (address_load) addr_q <= start_val;
        else if (enable) addr_q <= addr_q + 1'b1;
    end

    // A zero length behaves as a one-cycle run so the event still fires at count 0
    assign end_eff     = (end_q == '0) ? LENGTH_WIDTH'(1) : end_q;
    assign count_event = (count_q == end_eff - LENGTH_WIDTH'(1));
    assign count_val   = addr_q;
endmodule

// File: tb/tb_length_load_counter.sv
// tb_length_load_counter: directed scoreboard bench for length_load_counter
module tb_length_load_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] end_val = '0;
    logic        length_load = 1'b0;
    logic        count_event;
    logic [39:0] start_val = '0;
    logic        address_load = 1'b0;
    logic [39:0] count_val;

    typedef struct {
        string       tag;
        logic        ev;
        logic [39:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_end = '0;
    logic [39:0] m_addr = '0;

    length_load_counter #(.LENGTH_WIDTH(32), .ADDRESS_WIDTH(40)) dut (
        .clk(clk), .rst(rst), .enable(enable), .end_val(end_val),
        .length_load(length_load), .count_event(count_event),
        .start_val(start_val), .address_load(address_load), .count_val(count_val)
    );

    always #5 clk = ~clk;

    function automatic logic model_ev();
        return (m_end == 0) ? (m_cnt == 0) : (m_cnt == m_end - 1);
    endfunction

    task automatic check(input string tag, input logic ev_exp, input logic [39:0] val_exp);
        n_checks++;
        assert (count_event === ev_exp && count_val === val_exp)
        else begin
            n_errors++;
            $error("FAIL %s: count_event=%0b count_val=%h expected count_event=%0b count_val=%h",
                   tag, count_event, count_val, ev_exp, val_exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = '0;
        m_end = '0;
        m_addr = '0;
    endtask

    // Drive one cycle, push the model's post-edge prediction, then pop and compare after the edge
    task automatic step(input string tag, input logic en, input logic ll, input logic [31:0] ev_in,
                        input logic al, input logic [39:0] sv);
        exp_t e;
        enable = en;
        length_load = ll;
        end_val = ev_in;
        address_load = al;
        start_val = sv;
        if (ll) m_end = ev_in;
        if (en) m_cnt = m_cnt + 1;
        if (al) m_addr = sv;
        else if (en) m_addr = m_addr + 1;
        e.tag = tag;
        e.ev = model_ev();
        e.val = m_addr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, e.ev, e.val);
    endtask

    initial begin
        #3;
        check("reset_state", 1'b1, 40'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        step("len_load4", 1'b0, 1'b1, 32'd4, 1'b0, 40'h0);
        check("len4_cnt0_direct", 1'b0, 40'h0);
        step("run_cnt1", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("run_cnt2", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("run_cnt3", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("run_cnt3_direct", 1'b1, 40'h3);
        step("run_cnt4_past", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("run_cnt5_past", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);

        step("addr_load10", 1'b0, 1'b0, 32'd0, 1'b1, 40'h10);
        step("addr_inc11", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("addr_inc12", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("addr_inc13", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("addr_13_direct", 1'b0, 40'h13);

        step("load_prio5", 1'b1, 1'b0, 32'd0, 1'b1, 40'h5);
        check("load_prio5_direct", 1'b0, 40'h5);
        step("addr_hold", 1'b0, 1'b0, 32'd0, 1'b0, 40'h0);

        step("addr_load_max", 1'b0, 1'b0, 32'd0, 1'b1, 40'hFF_FFFF_FFFF);
        step("addr_wrap", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("addr_wrap_direct", 1'b0, 40'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("reset_again", 1'b1, 40'h0);
        @(negedge clk);
        rst = 1'b0;
        step("tog_load4", 1'b0, 1'b1, 32'd4, 1'b0, 40'h0);
        step("tog_en1", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("tog_en0", 1'b0, 1'b0, 32'd0, 1'b0, 40'h0);
        step("tog_en1b", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("tog_en0b", 1'b0, 1'b0, 32'd0, 1'b0, 40'h0);
        step("tog_en1c", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("tog_event_direct", 1'b1, 40'h3);
        step("len_load1", 1'b0, 1'b1, 32'd1, 1'b0, 40'h0);
        check("len1_cnt3_direct", 1'b0, 40'h3);

        step("mid_setup", 1'b0, 1'b1, 32'd4, 1'b1, 40'h1E);
        step("mid_run1", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        step("mid_run2", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("mid_pre_reset", 1'b0, 40'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset", 1'b1, 40'h0);
        enable = 1'b1;
        length_load = 1'b1;
        end_val = 32'd4;
        address_load = 1'b1;
        start_val = 40'h77;
        @(posedge clk);
        #1;
        check("reset_override", 1'b1, 40'h0);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_idle", 1'b0, 1'b0, 32'd0, 1'b0, 40'h0);
        check("post_reset_direct", 1'b1, 40'h0);
        step("post_reset_en", 1'b1, 1'b0, 32'd0, 1'b0, 40'h0);
        check("post_reset_en_direct", 1'b0, 40'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
